// File: rtl/alu_operand_stage.sv
// Registered operand staging ahead of the ALU adder: 2-entry skid buffer with
// a flopped in_ready and writeback forwarding into every held entry.
module alu_operand_stage #(
  parameter int OPERAND_LENGTH = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [OPERAND_LENGTH-1:0] in_opd1,
  input  logic [OPERAND_LENGTH-1:0] in_opd2,
  input  logic [REG_ADDR_WIDTH-1:0] in_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] in_rs2,
  input  logic                      in_rs1_used,
  input  logic                      in_rs2_used,
  input  logic [2:0]                in_alu_op_select,
  input  logic [REG_ADDR_WIDTH-1:0] in_rd,
  input  logic                      fwd_valid,
  input  logic [REG_ADDR_WIDTH-1:0] fwd_rd,
  input  logic [OPERAND_LENGTH-1:0] fwd_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OPERAND_LENGTH-1:0] opd1,
  output logic [OPERAND_LENGTH-1:0] opd2,
  output logic [2:0]                alu_op_select,
  output logic [REG_ADDR_WIDTH-1:0] out_rd
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  typedef struct packed {
    logic [OPERAND_LENGTH-1:0] opd1;
    logic [OPERAND_LENGTH-1:0] opd2;
    logic [REG_ADDR_WIDTH-1:0] rs1;
    logic [REG_ADDR_WIDTH-1:0] rs2;
    logic                      rs1_used;
    logic                      rs2_used;
    logic [2:0]                op;
    logic [REG_ADDR_WIDTH-1:0] rd;
  } entry_t;

  // Register x0 is hardwired, so a writeback to index 0 never forwards.
  function automatic entry_t applyFwd(
    input entry_t                    e,
    input logic                      f_valid,
    input logic [REG_ADDR_WIDTH-1:0] f_rd,
    input logic [OPERAND_LENGTH-1:0] f_data
  );
    entry_t r;
    r = e;
    if (f_valid && (f_rd != '0)) begin
      if (e.rs1_used && (e.rs1 == f_rd)) r.opd1 = f_data;
      if (e.rs2_used && (e.rs2 == f_rd)) r.opd2 = f_data;
    end
    return r;
  endfunction

  state_t r_state;
  state_t w_state_next;
  entry_t r_head;
  entry_t r_skid;
  entry_t w_head_next;
  entry_t w_skid_next;
  entry_t w_in;
  entry_t w_in_fwd;
  logic   r_in_ready;
  logic   w_accept;
  logic   w_consume;

  assign w_in = '{opd1: in_opd1, opd2: in_opd2, rs1: in_rs1, rs2: in_rs2,
                  rs1_used: in_rs1_used, rs2_used: in_rs2_used,
                  op: in_alu_op_select, rd: in_rd};

  assign in_ready      = r_in_ready;
  assign out_valid     = (r_state != EMPTY);
  assign w_accept      = in_valid & r_in_ready;
  assign w_consume     = out_valid & out_ready;
  assign opd1          = r_head.opd1;
  assign opd2          = r_head.opd2;
  assign alu_op_select = r_head.op;
  assign out_rd        = r_head.rd;

  // Held entries track writeback every cycle; a consumed head is simply replaced.
  always_comb begin
    w_state_next = r_state;
    w_in_fwd     = applyFwd(w_in, fwd_valid, fwd_rd, fwd_data);
    w_head_next  = applyFwd(r_head, fwd_valid, fwd_rd, fwd_data);
    w_skid_next  = applyFwd(r_skid, fwd_valid, fwd_rd, fwd_data);
    if (flush) begin
      w_state_next = EMPTY;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_accept) begin
            w_head_next  = w_in_fwd;
            w_state_next = ONE;
          end
        end
        ONE: begin
          if (w_accept && w_consume) begin
            w_head_next = w_in_fwd;
          end else if (w_accept) begin
            w_skid_next  = w_in_fwd;
            w_state_next = TWO;
          end else if (w_consume) begin
            w_state_next = EMPTY;
          end
        end
        TWO: begin
          if (w_consume) begin
            w_head_next  = w_skid_next;
            w_state_next = ONE;
          end
        end
        default: w_state_next = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= EMPTY;
      r_head     <= '0;
      r_skid     <= '0;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_next;
      r_head     <= w_head_next;
      r_skid     <= w_skid_next;
      r_in_ready <= (w_state_next != TWO);
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed self-checking bench for alu_operand_stage: streaming, backpressure,
// forwarding into held/incoming entries, flush and asynchronous reset.
module tb_alu_operand_stage;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_opd1;
  logic [31:0] in_opd2;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic        in_rs1_used;
  logic        in_rs2_used;
  logic [2:0]  in_alu_op_select;
  logic [4:0]  in_rd;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] opd1;
  logic [31:0] opd2;
  logic [2:0]  alu_op_select;
  logic [4:0]  out_rd;

  int checkCount = 0;
  int failCount  = 0;

  alu_operand_stage #(.OPERAND_LENGTH(32), .REG_ADDR_WIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opd1(in_opd1), .in_opd2(in_opd2),
    .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_rs1_used(in_rs1_used), .in_rs2_used(in_rs2_used),
    .in_alu_op_select(in_alu_op_select), .in_rd(in_rd),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .opd1(opd1), .opd2(opd2), .alu_op_select(alu_op_select), .out_rd(out_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] o1, input logic [31:0] o2,
                               input logic [4:0] r1, input logic [4:0] r2,
                               input logic u1, input logic u2,
                               input logic [2:0] op, input logic [4:0] rd);
    in_valid = v; in_opd1 = o1; in_opd2 = o2; in_rs1 = r1; in_rs2 = r2;
    in_rs1_used = u1; in_rs2_used = u2; in_alu_op_select = op; in_rd = rd;
  endtask

  task automatic setForward(input logic v, input logic [4:0] rd, input logic [31:0] data);
    fwd_valid = v; fwd_rd = rd; fwd_data = data;
  endtask

  task automatic idleInput();
    applyStimulus(1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0, 3'd0, 5'd0);
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    idleInput();
    out_ready = 1'b1;
    stepCycle();
    stepCycle();
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    idleInput();
    setForward(1'b0, 5'd0, 32'h0);
    repeat (2) stepCycle();
    checkOutput("reset_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("reset_in_ready", {31'b0, in_ready}, 32'd1);
    checkOutput("reset_opd1", opd1, 32'd0);
    checkOutput("reset_opd2", opd2, 32'd0);
    checkOutput("reset_rd", {27'b0, out_rd}, 32'd0);
    checkOutput("reset_op", {29'b0, alu_op_select}, 32'd0);
    #3 rst_n = 1'b1;
    stepCycle();

    // Streaming with out_ready held high
    out_ready = 1'b1;
    applyStimulus(1'b1, 32'd5, 32'd3, 5'd0, 5'd0, 1'b0, 1'b0, 3'b000, 5'd1);
    stepCycle();
    checkOutput("stream_A_valid", {31'b0, out_valid}, 32'd1);
    checkOutput("stream_A_opd1", opd1, 32'd5);
    checkOutput("stream_A_opd2", opd2, 32'd3);
    checkOutput("stream_A_op", {29'b0, alu_op_select}, 32'd0);
    checkOutput("stream_A_ready", {31'b0, in_ready}, 32'd1);
    applyStimulus(1'b1, 32'd10, 32'd4, 5'd0, 5'd0, 1'b0, 1'b0, 3'b001, 5'd2);
    stepCycle();
    checkOutput("stream_B_valid", {31'b0, out_valid}, 32'd1);
    checkOutput("stream_B_opd1", opd1, 32'd10);
    checkOutput("stream_B_opd2", opd2, 32'd4);
    checkOutput("stream_B_op", {29'b0, alu_op_select}, 32'd1);
    checkOutput("stream_B_rd", {27'b0, out_rd}, 32'd2);
    checkOutput("stream_B_ready", {31'b0, in_ready}, 32'd1);
    idleInput();
    stepCycle();
    checkOutput("stream_drained", {31'b0, out_valid}, 32'd0);

    // Backpressure fills the skid
    out_ready = 1'b0;
    applyStimulus(1'b1, 32'd5, 32'd3, 5'd0, 5'd0, 1'b0, 1'b0, 3'b000, 5'd1);
    stepCycle();
    checkOutput("bp_one_ready", {31'b0, in_ready}, 32'd1);
    applyStimulus(1'b1, 32'd10, 32'd4, 5'd0, 5'd0, 1'b0, 1'b0, 3'b001, 5'd2);
    stepCycle();
    checkOutput("bp_two_ready", {31'b0, in_ready}, 32'd0);
    checkOutput("bp_two_opd1", opd1, 32'd5);
    checkOutput("bp_two_valid", {31'b0, out_valid}, 32'd1);
    applyStimulus(1'b1, 32'd99, 32'd99, 5'd0, 5'd0, 1'b0, 1'b0, 3'b111, 5'd9);
    stepCycle();
    checkOutput("bp_stall_opd1", opd1, 32'd5);
    idleInput();
    out_ready = 1'b1;
    stepCycle();
    checkOutput("bp_release_opd1", opd1, 32'd10);
    checkOutput("bp_release_rd", {27'b0, out_rd}, 32'd2);
    checkOutput("bp_release_ready", {31'b0, in_ready}, 32'd1);
    stepCycle();
    checkOutput("bp_drained", {31'b0, out_valid}, 32'd0);
    out_ready = 1'b0;

    // Forwarding into a stalled head
    applyStimulus(1'b1, 32'h22, 32'h11, 5'd0, 5'd7, 1'b0, 1'b1, 3'b000, 5'd3);
    stepCycle();
    idleInput();
    checkOutput("stall_pre_opd2", opd2, 32'h11);
    setForward(1'b1, 5'd7, 32'hDEADBEEF);
    stepCycle();
    setForward(1'b0, 5'd0, 32'h0);
    checkOutput("stall_fwd_opd2", opd2, 32'hDEADBEEF);
    checkOutput("stall_fwd_opd1", opd1, 32'h22);
    drain();

    applyStimulus(1'b1, 32'h22, 32'h11, 5'd0, 5'd0, 1'b0, 1'b1, 3'b000, 5'd3);
    stepCycle();
    idleInput();
    setForward(1'b1, 5'd0, 32'hDEADBEEF);
    stepCycle();
    setForward(1'b0, 5'd0, 32'h0);
    checkOutput("stall_x0_opd2", opd2, 32'h11);
    drain();

    // Forwarding at capture; rs2 matches but is unused
    applyStimulus(1'b1, 32'd1, 32'd9, 5'd3, 5'd3, 1'b1, 1'b0, 3'b010, 5'd4);
    setForward(1'b1, 5'd3, 32'h80000000);
    stepCycle();
    idleInput();
    setForward(1'b0, 5'd0, 32'h0);
    checkOutput("capture_opd1", opd1, 32'h80000000);
    checkOutput("capture_opd2_unused", opd2, 32'd9);
    checkOutput("capture_op", {29'b0, alu_op_select}, 32'd2);
    drain();

    // Forwarding into the skid entry, visible once it moves to head
    applyStimulus(1'b1, 32'hA, 32'hB, 5'd0, 5'd0, 1'b0, 1'b0, 3'b000, 5'd5);
    stepCycle();
    applyStimulus(1'b1, 32'hC, 32'hD, 5'd6, 5'd6, 1'b1, 1'b1, 3'b001, 5'd6);
    stepCycle();
    idleInput();
    setForward(1'b1, 5'd6, 32'h12345678);
    stepCycle();
    setForward(1'b0, 5'd0, 32'h0);
    checkOutput("skid_head_untouched", opd1, 32'hA);
    out_ready = 1'b1;
    stepCycle();
    out_ready = 1'b0;
    checkOutput("skid_fwd_opd1", opd1, 32'h12345678);
    checkOutput("skid_fwd_opd2", opd2, 32'h12345678);
    drain();

    // Flush while full with an incoming entry
    applyStimulus(1'b1, 32'h100, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0, 3'b000, 5'd7);
    stepCycle();
    applyStimulus(1'b1, 32'h200, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0, 3'b000, 5'd8);
    stepCycle();
    applyStimulus(1'b1, 32'h300, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0, 3'b000, 5'd9);
    flush = 1'b1;
    stepCycle();
    flush = 1'b0;
    idleInput();
    checkOutput("flush_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("flush_ready", {31'b0, in_ready}, 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      stepCycle();
      checkOutput("flush_no_emerge", {31'b0, out_valid}, 32'd0);
    end
    out_ready = 1'b0;

    // Asynchronous reset while full
    applyStimulus(1'b1, 32'h55, 32'h66, 5'd0, 5'd0, 1'b0, 1'b0, 3'b000, 5'd10);
    stepCycle();
    applyStimulus(1'b1, 32'h77, 32'h88, 5'd0, 5'd0, 1'b0, 1'b0, 3'b000, 5'd11);
    stepCycle();
    idleInput();
    checkOutput("pre_reset_ready", {31'b0, in_ready}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_reset_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("async_reset_ready", {31'b0, in_ready}, 32'd1);
    checkOutput("async_reset_opd1", opd1, 32'd0);
    stepCycle();
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      stepCycle();
      checkOutput("post_reset_empty", {31'b0, out_valid}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
